// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and bit-timing helpers used by uart_tx and uart_rx.
// The PARITY state is only entered when UART_TX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    // Truncating division so both ends of a link derive the same bit period.
    function automatic int unsigned cycles_per_bit(input int unsigned clk_hz, input int unsigned bit_rate);
        return clk_hz / bit_rate;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEFAULT_CLK_HZ         = 50_000_000;
    localparam int unsigned DEFAULT_BIT_RATE       = 115_200;
    localparam int unsigned DEFAULT_CYCLES_PER_BIT = cycles_per_bit(DEFAULT_CLK_HZ, DEFAULT_BIT_RATE);
    localparam int unsigned DEFAULT_BIT_CNT_W      = cnt_width(DEFAULT_CYCLES_PER_BIT);

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts clk cycles and pulses bit_done on the last cycle of each CYCLES-long period.
// Held at zero while clear is high, so the first period starts on the cycle clear drops.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned CYCLES = DEFAULT_CYCLES_PER_BIT,
    parameter int unsigned CNT_W  = cnt_width(CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] count;

    assign bit_done = (count == LAST) && !clear;

    always_ff @(posedge clk) begin
        if (reset || clear || bit_done) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, PAYLOAD_BITS data bits LSB-first, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned BIT_RATE     = DEFAULT_BIT_RATE,
    parameter int unsigned CLK_HZ       = DEFAULT_CLK_HZ,
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    uart_tx_en,
    input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
    output logic                    uart_tx_busy,
    output logic                    uart_txd
);

    localparam int unsigned CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int unsigned BIT_CNT_W      = cnt_width(CYCLES_PER_BIT);
    localparam int unsigned IDX_W          = cnt_width(PAYLOAD_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PAYLOAD_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    uart_state_t             state, state_next;
    logic [IDX_W-1:0]        idx, idx_next;
    logic [PAYLOAD_BITS-1:0] data_q, data_next;
    logic                    txd_next;
    logic                    bit_done;

    uart_bit_timer #(
        .CYCLES (CYCLES_PER_BIT),
        .CNT_W  (BIT_CNT_W)
    ) u_bit_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (state == IDLE),
        .bit_done (bit_done)
    );

    // Line and busy are registered from the next state so they change on the same edge as the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            data_q       <= '0;
            uart_txd     <= 1'b1;
            uart_tx_busy <= 1'b0;
        end else begin
            state        <= state_next;
            idx          <= idx_next;
            data_q       <= data_next;
            uart_txd     <= txd_next;
            uart_tx_busy <= (state_next != IDLE);
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        data_next  = data_q;
        case (state)
            IDLE: begin
                if (uart_tx_en) begin
                    state_next = START;
                    data_next  = uart_tx_data;
                    idx_next   = '0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_next = DATA;
                    idx_next   = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (idx == LAST_IDX) begin
                        idx_next = '0;
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        idx_next = idx + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_next = STOP;
                    idx_next   = '0;
                end
            end
            STOP: begin
                // idx is reused to count stop bits
                if (bit_done) begin
                    if (idx == LAST_STOP) begin
                        state_next = IDLE;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    always_comb begin
        txd_next = 1'b1;
        case (state_next)
            START:   txd_next = 1'b0;
            DATA:    txd_next = data_next[idx_next];
            PARITY:  txd_next = ^data_next;
            default: txd_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at default timing; a line monitor decodes frames into a scoreboard.
// Build with UART_TX_PARITY_EN defined to also exercise the parity bit.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int unsigned CPB = 50_000_000 / 115_200;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NSLOT = 1 + 8 + 1 + 1;
`else
    localparam int unsigned NSLOT = 1 + 8 + 1;
`endif
    localparam int unsigned FRAME = NSLOT * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       uart_tx_en = 1'b0;
    logic [7:0] uart_tx_data = '0;
    logic       uart_tx_busy;
    logic       uart_txd;

    int          checks = 0;
    int          errors = 0;
    int          frame_err = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  rx_q[$];
    logic        line_q[$];
    int unsigned nbusy;

    uart_tx #(
        .BIT_RATE     (115_200),
        .CLK_HZ       (50_000_000),
        .PAYLOAD_BITS (8),
        .STOP_BITS    (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .uart_tx_en   (uart_tx_en),
        .uart_tx_data (uart_tx_data),
        .uart_tx_busy (uart_tx_busy),
        .uart_txd     (uart_txd)
    );

    always #10 clk = ~clk;

    // Expected line level for each bit slot of a frame carrying d.
    function automatic logic exp_level(input logic [7:0] d, input int unsigned slot);
        if (slot == 0) return 1'b0;
        if (slot <= 8) return d[slot-1];
`ifdef UART_TX_PARITY_EN
        if (slot == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic wait_n(input int unsigned n, output bit ab);
        ab = 1'b0;
        for (int unsigned k = 0; k < n; k++) begin
            @(negedge clk);
            if (reset) begin
                ab = 1'b1;
                break;
            end
        end
    endtask

    // Mid-bit sampling receiver; abandons a frame if reset is seen.
    initial begin : monitor
        bit         ab;
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (!reset && uart_txd === 1'b0) begin
                b = '0;
                wait_n(CPB / 2, ab);
                if (!ab && uart_txd !== 1'b0) frame_err++;
                for (int i = 0; i < 8; i++) begin
                    if (!ab) begin
                        wait_n(CPB, ab);
                        b[i] = uart_txd;
                    end
                end
`ifdef UART_TX_PARITY_EN
                if (!ab) begin
                    wait_n(CPB, ab);
                    if (!ab && uart_txd !== ^b) frame_err++;
                end
`endif
                if (!ab) begin
                    wait_n(CPB, ab);
                    if (!ab) begin
                        if (uart_txd !== 1'b1) frame_err++;
                        else rx_q.push_back(b);
                    end
                end
            end
        end
    end

    // Issues one request and records the line for every busy cycle.
    task automatic send_and_capture(input logic [7:0] d);
        int unsigned guard;
        line_q.delete();
        nbusy = 0;
        @(negedge clk);
        uart_tx_data = d;
        uart_tx_en   = 1'b1;
        exp_q.push_back(d);
        @(negedge clk);
        uart_tx_en = 1'b0;
        guard = 0;
        while (uart_tx_busy === 1'b1 && guard < 3 * FRAME) begin
            line_q.push_back(uart_txd);
            nbusy++;
            guard++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input string name);
        int unsigned g = 0;
        while (uart_tx_busy !== 1'b0 && g < 3 * FRAME) begin
            @(negedge clk);
            g++;
        end
        if (uart_tx_busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout busy=%b expected 0", name, uart_tx_busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (uart_txd !== 1'b1) begin errors++; $display("FAIL reset_txd got=%b exp=1", uart_txd); end
        checks++;
        if (uart_tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", uart_tx_busy); end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (uart_txd !== 1'b1 || uart_tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset txd=%b busy=%b exp txd=1 busy=0", uart_txd, uart_tx_busy);
        end
    endtask

    task automatic test_single();
        logic [7:0] e, a;
        int unsigned good;
        send_and_capture(8'h55);
        checks++;
        if (nbusy != FRAME) begin errors++; $display("FAIL single_busy_len got=%0d exp=%0d", nbusy, FRAME); end
        for (int unsigned s = 0; s < NSLOT; s++) begin
            good = 0;
            for (int unsigned k = 0; k < CPB; k++) begin
                if (s * CPB + k < line_q.size() && line_q[s*CPB+k] === exp_level(8'h55, s)) good++;
            end
            checks++;
            if (good != CPB) begin
                errors++;
                $display("FAIL single_slot%0d cycles_at_level=%0d exp=%0d level=%b", s, good, CPB, exp_level(8'h55, s));
            end
        end
        repeat (10) @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (rx_q.size() == 0) begin
            errors++;
            $display("FAIL single_rx got=none exp=%h", e);
        end else begin
            a = rx_q.pop_front();
            if (a !== e) begin errors++; $display("FAIL single_rx got=%h exp=%h", a, e); end
        end
    endtask

    task automatic test_busy_ignore();
        int unsigned n = 0;
        int unsigned late_busy = 0;
        logic [7:0] e, a;
        @(negedge clk);
        uart_tx_data = 8'hA3;
        uart_tx_en   = 1'b1;
        exp_q.push_back(8'hA3);
        @(negedge clk);
        uart_tx_en = 1'b0;
        while (uart_tx_busy === 1'b1 && n < 3 * FRAME) begin
            n++;
            if (n == 1000) begin
                uart_tx_data = 8'hFF;
                uart_tx_en   = 1'b1;
            end else begin
                uart_tx_en = 1'b0;
            end
            @(negedge clk);
        end
        uart_tx_en = 1'b0;
        checks++;
        if (n != FRAME) begin errors++; $display("FAIL ignore_busy_len got=%0d exp=%0d", n, FRAME); end
        for (int unsigned k = 0; k < FRAME + 100; k++) begin
            if (uart_tx_busy !== 1'b0 || uart_txd !== 1'b1) late_busy++;
            @(negedge clk);
        end
        checks++;
        if (late_busy != 0) begin errors++; $display("FAIL ignore_no_second_frame active_cycles=%0d exp=0", late_busy); end
        e = exp_q.pop_front();
        checks++;
        if (rx_q.size() != 1) begin
            errors++;
            $display("FAIL ignore_rx_count got=%0d exp=1", rx_q.size());
        end
        if (rx_q.size() > 0) begin
            a = rx_q.pop_front();
            checks++;
            if (a !== e) begin errors++; $display("FAIL ignore_rx got=%h exp=%h", a, e); end
        end
        rx_q.delete();
    endtask

    task automatic test_back_to_back();
        int unsigned gap = 0;
        int unsigned g = 0;
        int unsigned bad_idle = 0;
        logic [7:0] e, a;
        @(negedge clk);
        uart_tx_data = 8'h00;
        uart_tx_en   = 1'b1;
        exp_q.push_back(8'h00);
        @(negedge clk);
        uart_tx_data = 8'hFF;
        exp_q.push_back(8'hFF);
        while (uart_tx_busy === 1'b1 && g < 3 * FRAME) begin @(negedge clk); g++; end
        while (uart_tx_busy === 1'b0 && gap < 10) begin
            if (uart_txd !== 1'b1) bad_idle++;
            gap++;
            @(negedge clk);
        end
        uart_tx_en = 1'b0;
        checks++;
        if (gap != 1 || bad_idle != 0) begin
            errors++;
            $display("FAIL b2b_gap idle_cycles=%0d low_in_gap=%0d exp 1 and 0", gap, bad_idle);
        end
        wait_idle("b2b");
        repeat (10) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rx_q.size() == 0) begin
                errors++;
                $display("FAIL b2b_rx got=none exp=%h", e);
            end else begin
                a = rx_q.pop_front();
                if (a !== e) begin errors++; $display("FAIL b2b_rx got=%h exp=%h", a, e); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int unsigned n = 1;
        logic [7:0] e, a;
        @(negedge clk);
        uart_tx_data = 8'h0F;
        uart_tx_en   = 1'b1;
        @(negedge clk);
        uart_tx_en = 1'b0;
        while (n < 2000) begin @(negedge clk); n++; end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (uart_txd !== 1'b1 || uart_tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_line txd=%b busy=%b exp txd=1 busy=0", uart_txd, uart_tx_busy);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (rx_q.size() != 0) begin errors++; $display("FAIL midreset_abandoned rx_count=%0d exp=0", rx_q.size()); end
        rx_q.delete();
        send_and_capture(8'h81);
        checks++;
        if (nbusy != FRAME) begin errors++; $display("FAIL midreset_next_len got=%0d exp=%0d", nbusy, FRAME); end
        repeat (10) @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (rx_q.size() == 0) begin
            errors++;
            $display("FAIL midreset_next_rx got=none exp=%h", e);
        end else begin
            a = rx_q.pop_front();
            if (a !== e) begin errors++; $display("FAIL midreset_next_rx got=%h exp=%h", a, e); end
        end
    endtask

    task automatic test_loopback();
        logic [7:0] e, a, b;
        int unsigned g;
        for (int i = 0; i < 6; i++) begin
            g = 0;
            while (uart_tx_busy === 1'b1 && g < 3 * FRAME) begin @(negedge clk); g++; end
            b = 8'($urandom);
            uart_tx_data = b;
            uart_tx_en   = 1'b1;
            exp_q.push_back(b);
            @(negedge clk);
        end
        uart_tx_en = 1'b0;
        wait_idle("loopback");
        repeat (10) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rx_q.size() == 0) begin
                errors++;
                $display("FAIL loopback_rx got=none exp=%h", e);
            end else begin
                a = rx_q.pop_front();
                if (a !== e) begin errors++; $display("FAIL loopback_rx got=%h exp=%h", a, e); end
            end
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] e, a;
        logic [7:0] pat [2];
        logic       par [2];
        pat[0] = 8'h07; par[0] = 1'b1;
        pat[1] = 8'h03; par[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            send_and_capture(pat[i]);
            checks++;
            if (nbusy != FRAME) begin errors++; $display("FAIL parity_len_%h got=%0d exp=%0d", pat[i], nbusy, FRAME); end
            checks++;
            if (line_q.size() <= 9 * CPB + CPB / 2) begin
                errors++;
                $display("FAIL parity_bit_%h got=none exp=%b", pat[i], par[i]);
            end else if (line_q[9*CPB+CPB/2] !== par[i]) begin
                errors++;
                $display("FAIL parity_bit_%h got=%b exp=%b", pat[i], line_q[9*CPB+CPB/2], par[i]);
            end
            repeat (10) @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (rx_q.size() == 0) begin
                errors++;
                $display("FAIL parity_rx got=none exp=%h", e);
            end else begin
                a = rx_q.pop_front();
                if (a !== e) begin errors++; $display("FAIL parity_rx got=%h exp=%h", a, e); end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_loopback();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        checks++;
        if (frame_err != 0) begin errors++; $display("FAIL line_framing errors=%0d exp=0", frame_err); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
